// File: rtl/dmem_loader_pkg.sv
// Shared types and constants for the data memory loader.
// Checksum support is compiled in with DMEM_LOADER_CHECKSUM_EN.
package dmem_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      FIN   = 2'd3
   } state_e;

   localparam int CSUM_W = 8;

   function automatic int bytes_per_word(input int data_width);
      return (data_width + 7) / 8;
   endfunction

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// Little-endian byte-to-word packer: tracks the byte lane and merges each byte
// into the partial word; word_valid fires on the byte that completes a word.
module byte_packer #(
   parameter int DATA_WIDTH = 20,
   parameter int BPW        = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_valid
);

   localparam int IW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IW-1:0] LAST = IW'(BPW - 1);

   logic [IW-1:0]         idx;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] merged;

   // The top lane may be narrower than a byte; its excess high bits are dropped.
   for (genvar k = 0; k < BPW; k++) begin : g_lane
      localparam int LO = 8 * k;
      localparam int W  = (DATA_WIDTH - LO < 8) ? DATA_WIDTH - LO : 8;
      assign merged[LO +: W] = (idx == IW'(k)) ? in_data[W-1:0] : acc[LO +: W];
   end

   assign word       = merged;
   assign word_valid = in_valid && (idx == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx <= '0;
         acc <= '0;
      end else if (clr) begin
         idx <= '0;
         acc <= '0;
      end else if (in_valid) begin
         if (idx == LAST) begin
            idx <= '0;
            acc <= '0;
         end else begin
            idx <= idx + IW'(1);
            acc <= merged;
         end
      end
   end

endmodule

// File: rtl/dmem_loader.sv
// Streaming data memory loader: packs a byte stream into words and writes them
// from a base address while stalling the core. Optional: DMEM_LOADER_CHECKSUM_EN.
module dmem_loader
   import dmem_loader_pkg::*;
#(
   parameter int DATA_WIDTH    = 20,
   parameter int ADDRESS_WIDTH = 8,
   parameter int MEM_SIZE      = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   word_count,
   input  logic                     s_valid,
   input  logic [7:0]               s_data,
   output logic                     s_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     core_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int AW  = ADDRESS_WIDTH;
   localparam int BPW = bytes_per_word(DATA_WIDTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [AW:0] CAP = (AW+1)'(MEM_SIZE);

`ifdef DMEM_LOADER_CHECKSUM_EN
   localparam state_e AFTER_LOAD = CHECK;
`else
   localparam state_e AFTER_LOAD = FIN;
`endif

   state_e                state;
   logic [AW-1:0]         base_q;
   logic [AW:0]           cnt_q;
   logic [AW:0]           widx;
   logic                  last_q;
   logic [AW:0]           cnt_cap;
   logic                  take;
   logic                  pk_valid;
   logic                  pk_word_valid;
   logic [DATA_WIDTH-1:0] pk_word;

   assign cnt_cap   = (word_count > CAP) ? CAP : word_count;
   // Once the last word is packed, the write cycle drains before leaving LOAD.
   assign s_ready   = ((state == LOAD) && !last_q) || (state == CHECK);
   assign take      = s_valid && s_ready;
   assign pk_valid  = take && (state == LOAD);
   assign busy      = (state != IDLE);
   assign core_hold = busy;
   assign done      = (state == FIN);

   byte_packer #(.DATA_WIDTH(DATA_WIDTH), .BPW(BPW)) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        ((state == IDLE) && start),
      .in_valid   (pk_valid),
      .in_data    (s_data),
      .word       (pk_word),
      .word_valid (pk_word_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         base_q    <= '0;
         cnt_q     <= '0;
         widx      <= '0;
         last_q    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= pk_word_valid;
         if (pk_word_valid) begin
            mem_addr  <= base_q + widx[AW-1:0];
            mem_wdata <= pk_word;
            widx      <= widx + ONE;
            if (widx + ONE == cnt_q) last_q <= 1'b1;
         end
         case (state)
            IDLE: if (start) begin
               base_q <= base_addr;
               cnt_q  <= cnt_cap;
               widx   <= '0;
               last_q <= 1'b0;
               state  <= (cnt_cap == '0) ? FIN : LOAD;
            end
            LOAD: if (last_q) begin
               last_q <= 1'b0;
               state  <= AFTER_LOAD;
            end
            CHECK: if (take) state <= FIN;
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0] csum;
   logic              err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum  <= '0;
         err_q <= 1'b0;
      end else if ((state == IDLE) && start) begin
         csum  <= '0;
         err_q <= 1'b0;
      end else if (pk_valid) begin
         csum <= csum + s_data;
      end else if ((state == CHECK) && take) begin
         err_q <= (s_data != csum);
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_loader.sv
// Scoreboard bench for dmem_loader: stimulus pushes expected writes, a negedge
// monitor pops and compares each mem_we beat.
module tb_dmem_loader;
   localparam int DW = 20;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   word_count = '0;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data = '0;
   logic          s_ready, mem_we, core_hold, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic [AW+DW-1:0] exp_q[$];
   logic [7:0] sum;
   bit watch_ready = 0;
   bit seen_ready  = 0;

   dmem_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(256)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .core_hold(core_hold), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (watch_ready && s_ready) seen_ready = 1;
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
            check("write_data", 32'(mem_wdata), 32'(e[DW-1:0]));
         end
      end
   end

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic go(input logic [AW-1:0] b, input logic [AW:0] c);
      base_addr = b;
      word_count = c;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      sum = 8'h00;
      check("busy_after_start", 32'(busy), 32'd1);
      check("hold_after_start", 32'(core_hold), 32'd1);
   endtask

   task automatic put(input logic [7:0] b, input int gap, input bit pulse);
      int t = 0;
      s_valid = 1'b1;
      s_data = b;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got s_ready 0 expected 1");
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      sum = sum + b;
      for (int g = 0; g < gap; g++) begin
         if (pulse) begin
            start = 1'b1;
            base_addr = 8'h80;
            word_count = 9'd1;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_done(input int exp_k, input bit exp_err);
      int k = 0;
      bit got = 0;
      repeat (40) begin
         @(negedge clk);
         k++;
         if (done) begin
            got = 1;
            break;
         end
         @(posedge clk);
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got no done expected done");
      end else begin
         check("done_latency", 32'(k), 32'(exp_k));
         check("err_at_done", 32'(err), 32'(exp_err));
      end
      @(posedge clk); #1;
      check("idle_after_done", 32'(busy), 32'd0);
   endtask

   task automatic finish_load(input bit bad);
`ifdef DMEM_LOADER_CHECKSUM_EN
      logic [7:0] tr;
      tr = bad ? sum + 8'd1 : sum;
      put(tr, 0, 0);
      wait_done(1, bad);
`else
      wait_done(2, bad);
`endif
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 32'({s_ready, mem_we, core_hold, busy, done, err}), 32'd0);
      check("reset_addr", 32'(mem_addr), 32'd0);
      check("reset_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic two-word load at full rate
      expect_wr(8'h10, 20'h51234);
      expect_wr(8'h11, 20'h7ABCD);
      go(8'h10, 9'd2);
      put(8'h34, 0, 0); put(8'h12, 0, 0); put(8'h05, 0, 0);
      put(8'hCD, 0, 0); put(8'hAB, 0, 0); put(8'hF7, 0, 0);
      finish_load(0);

      // Zero-length load
      seen_ready = 0;
      watch_ready = 1;
      go(8'h33, 9'd0);
      wait_done(1, 0);
      watch_ready = 0;
      check("ready_count0", 32'(seen_ready), 32'd0);

      // Address wrap
      expect_wr(8'hFF, 20'h32211);
      expect_wr(8'h00, 20'hCBBAA);
      go(8'hFF, 9'd2);
      put(8'h11, 0, 0); put(8'h22, 0, 0); put(8'h33, 0, 0);
      put(8'hAA, 0, 0); put(8'hBB, 0, 0); put(8'hCC, 0, 0);
      finish_load(0);

      // Gapped stream with stray start pulses
      expect_wr(8'h10, 20'h51234);
      expect_wr(8'h11, 20'h7ABCD);
      go(8'h10, 9'd2);
      put(8'h34, 1, 1); put(8'h12, 1, 0); put(8'h05, 1, 1);
      put(8'hCD, 1, 0); put(8'hAB, 1, 1); put(8'hF7, 0, 0);
      finish_load(0);

      // Reset mid-word discards the partial word
      go(8'h40, 9'd2);
      put(8'hAA, 0, 0); put(8'hBB, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ctrl", 32'({s_ready, mem_we, core_hold, busy, done, err}), 32'd0);
      check("midrst_addr", 32'(mem_addr), 32'd0);
      check("midrst_wdata", 32'(mem_wdata), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      expect_wr(8'h00, 20'h00001);
      go(8'h00, 9'd1);
      put(8'h01, 0, 0); put(8'h00, 0, 0); put(8'h00, 0, 0);
      finish_load(0);

`ifdef DMEM_LOADER_CHECKSUM_EN
      expect_wr(8'h20, 20'h30201);
      go(8'h20, 9'd1);
      put(8'h01, 0, 0); put(8'h02, 0, 0); put(8'h03, 0, 0);
      put(8'h06, 0, 0);
      wait_done(1, 0);

      expect_wr(8'h20, 20'h30201);
      go(8'h20, 9'd1);
      put(8'h01, 0, 0); put(8'h02, 0, 0); put(8'h03, 0, 0);
      put(8'h07, 0, 0);
      wait_done(1, 1);
      check("err_sticky", 32'(err), 32'd1);
      go(8'h21, 9'd0);
      wait_done(1, 0);
`endif

      repeat (3) @(posedge clk);
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
